// File: rtl/video_mux_pkg.sv
// Shared types for the video source switcher: output mode, switch FSM state, pixel bundle.
// Colour channels are carried at the widest supported width and sliced down by the user.
package video_mux_pkg;

  localparam int PIX_CW = 16;

  typedef enum logic {
    PASS    = 1'b0,
    OVERLAY = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    RUN,
    PENDING,
    BLANK
  } state_e;

  typedef struct packed {
    logic [PIX_CW-1:0] red;
    logic [PIX_CW-1:0] green;
    logic [PIX_CW-1:0] blue;
    logic              hsync;
    logic              vsync;
    logic              active;
  } pixel_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge strobe: the previous level is registered, the strobe is combinational so it
// fires in the same cycle the edge appears. No backpressure.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/video_source_switcher.sv
// Frame-synchronous video source switch with optional black frames and keyed overlay.
// All outputs registered, 1 cycle from the source inputs; no backpressure (pixel stream).
module video_source_switcher
  import video_mux_pkg::*;
#(
  parameter int                   NUM_SRC      = 2,
  parameter int                   COLOR_W      = 8,
  parameter int                   BLANK_FRAMES = 1,
  parameter logic [3*COLOR_W-1:0] KEY_COLOR    = '0
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [NUM_SRC-1:0][COLOR_W-1:0]    src_red_in,
  input  logic [NUM_SRC-1:0][COLOR_W-1:0]    src_green_in,
  input  logic [NUM_SRC-1:0][COLOR_W-1:0]    src_blue_in,
  input  logic [NUM_SRC-1:0]                 src_hsync_in,
  input  logic [NUM_SRC-1:0]                 src_vsync_in,
  input  logic [NUM_SRC-1:0]                 src_active_in,
  input  logic [$clog2(NUM_SRC)-1:0]         sel_in,
  input  logic                               sel_valid_in,
  input  logic                               mode_in,
  output logic [COLOR_W-1:0]                 red_out,
  output logic [COLOR_W-1:0]                 green_out,
  output logic [COLOR_W-1:0]                 blue_out,
  output logic                               hsync_out,
  output logic                               vsync_out,
  output logic                               active_draw_out,
  output logic [$clog2(NUM_SRC)-1:0]         active_sel_out,
  output logic                               busy_out
);

  localparam int SEL_W = $clog2(NUM_SRC);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic [SEL_W-1:0] sel_q, sel_d, pend_sel_q, pend_sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             boundary, req_legal, req_same, req;
  logic             fg_key;
  pixel_t           fg, bg, comp, out_q;
  logic             hi_unused;

  sync_edge_detect u_frame_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .sig_in   (src_vsync_in[sel_q]),
    .rise_out (boundary)
  );

  assign req_legal = sel_valid_in && (32'(sel_in) < NUM_SRC);
  assign req_same  = (state_q == RUN) && (sel_in == sel_q) && (mode_e'(mode_in) == mode_q);
  assign req       = req_legal && !req_same;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    pend_sel_d  = pend_sel_q;
    pend_mode_d = pend_mode_q;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: ;
      PENDING: begin
        if (boundary) begin
          sel_d   = pend_sel_q;
          mode_d  = pend_mode_q;
          cnt_d   = '0;
          state_d = (BLANK_FRAMES == 0) ? RUN : BLANK;
        end
      end
      BLANK: begin
        if (boundary) begin
          cnt_d = cnt_q + 4'd1;
          if (5'(cnt_q) + 5'd1 == 5'(BLANK_FRAMES)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A new request always wins over whatever the boundary decided; it waits for the next one.
    if (req) begin
      pend_sel_d  = sel_in;
      pend_mode_d = mode_e'(mode_in);
      state_d     = PENDING;
    end
  end

  // Pixel composition uses the next-cycle selection so the switch lands on the edge cycle.
  always_comb begin
    fg        = '0;
    bg        = '0;
    fg.red    = PIX_CW'(src_red_in[sel_d]);
    fg.green  = PIX_CW'(src_green_in[sel_d]);
    fg.blue   = PIX_CW'(src_blue_in[sel_d]);
    fg.hsync  = src_hsync_in[sel_d];
    fg.vsync  = src_vsync_in[sel_d];
    fg.active = src_active_in[sel_d];
    bg.red    = PIX_CW'(src_red_in[0]);
    bg.green  = PIX_CW'(src_green_in[0]);
    bg.blue   = PIX_CW'(src_blue_in[0]);
    bg.hsync  = src_hsync_in[0];
    bg.vsync  = src_vsync_in[0];
    bg.active = src_active_in[0];
    fg_key    = ({src_red_in[sel_d], src_green_in[sel_d], src_blue_in[sel_d]} == KEY_COLOR);
    comp      = fg;
    if (mode_d == OVERLAY) begin
      comp = bg;
      if (!fg_key && fg.active) begin
        comp.red   = fg.red;
        comp.green = fg.green;
        comp.blue  = fg.blue;
      end
    end
    if (state_d == BLANK) begin
      comp.red   = '0;
      comp.green = '0;
      comp.blue  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= RUN;
      sel_q       <= '0;
      mode_q      <= PASS;
      pend_sel_q  <= '0;
      pend_mode_q <= PASS;
      cnt_q       <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      pend_sel_q  <= pend_sel_d;
      pend_mode_q <= pend_mode_d;
      cnt_q       <= cnt_d;
      out_q       <= comp;
    end
  end

  assign red_out         = out_q.red[COLOR_W-1:0];
  assign green_out       = out_q.green[COLOR_W-1:0];
  assign blue_out        = out_q.blue[COLOR_W-1:0];
  assign hsync_out       = out_q.hsync;
  assign vsync_out       = out_q.vsync;
  assign active_draw_out = out_q.active;
  assign active_sel_out  = sel_q;
  assign busy_out        = (state_q != RUN);

  // Channel bits above COLOR_W are always zero.
  assign hi_unused = |{out_q.red >> COLOR_W, out_q.green >> COLOR_W, out_q.blue >> COLOR_W};

endmodule

// File: tb/tb_video_source_switcher.sv
// Scoreboarded bench: dut_a (4 sources, 1 black frame) and dut_b (5 sources, no black frame).
module tb_video_source_switcher;

  localparam int FRAME = 16;
  localparam int NCYC  = 256;

  logic clk_100_passthrough = 1'b0;
  always #5 clk_100_passthrough = ~clk_100_passthrough;

  logic            rst_n;
  logic [4:0][7:0] s_red, s_green, s_blue;
  logic [4:0]      s_hs, s_vs, s_act;
  logic            a_valid, a_mode, b_valid, b_mode;
  logic [1:0]      a_sel, a_as;
  logic [2:0]      b_sel, b_as;
  logic [7:0]      a_r, a_g, a_b, b_r, b_g, b_b;
  logic            a_hs, a_vs, a_ad, a_busy, b_hs, b_vs, b_ad, b_busy;

  video_source_switcher #(.NUM_SRC(4), .COLOR_W(8), .BLANK_FRAMES(1), .KEY_COLOR(24'h000000)) dut_a (
    .clk_in(clk_100_passthrough), .rst_n_in(rst_n),
    .src_red_in(s_red[3:0]), .src_green_in(s_green[3:0]), .src_blue_in(s_blue[3:0]),
    .src_hsync_in(s_hs[3:0]), .src_vsync_in(s_vs[3:0]), .src_active_in(s_act[3:0]),
    .sel_in(a_sel), .sel_valid_in(a_valid), .mode_in(a_mode),
    .red_out(a_r), .green_out(a_g), .blue_out(a_b),
    .hsync_out(a_hs), .vsync_out(a_vs), .active_draw_out(a_ad),
    .active_sel_out(a_as), .busy_out(a_busy)
  );

  video_source_switcher #(.NUM_SRC(5), .COLOR_W(8), .BLANK_FRAMES(0), .KEY_COLOR(24'h000000)) dut_b (
    .clk_in(clk_100_passthrough), .rst_n_in(rst_n),
    .src_red_in(s_red), .src_green_in(s_green), .src_blue_in(s_blue),
    .src_hsync_in(s_hs), .src_vsync_in(s_vs), .src_active_in(s_act),
    .sel_in(b_sel), .sel_valid_in(b_valid), .mode_in(b_mode),
    .red_out(b_r), .green_out(b_g), .blue_out(b_b),
    .hsync_out(b_hs), .vsync_out(b_vs), .active_draw_out(b_ad),
    .active_sel_out(b_as), .busy_out(b_busy)
  );

  typedef struct {
    int          cyc;
    logic [26:0] a_pix;
    int          a_sel;
    logic        a_busy;
    logic [26:0] b_pix;
    int          b_sel;
    logic        b_busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Pixel layout {red, green, blue, hsync, vsync, active}; vsync rises at frame position 0.
  function automatic logic [26:0] src_pix(int s, int p);
    logic [23:0] c;
    case (s)
      0:       c = 24'h00FF00;
      1:       c = (p % 2 == 1) ? 24'hFF0000 : 24'h000000;
      default: c = {8'(s * 16), 8'(p), 8'(s * 17)};
    endcase
    return {c, (p % 4 == 0), (p < 2), (p >= 4)};
  endfunction

  function automatic logic [26:0] exp_pix(int sel, bit mode, bit blank, bit rst_ok, int p);
    logic [26:0] fg, bg, r;
    fg = src_pix(sel, p);
    bg = src_pix(0, p);
    r  = fg;
    if (mode) begin
      r = bg;
      if (fg[26:3] != 24'h000000 && fg[0]) r[26:3] = fg[26:3];
    end
    if (blank) r[26:3] = '0;
    if (!rst_ok) r = '0;
    return r;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_100_passthrough);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_pixel", e.cyc, 32'({a_r, a_g, a_b, a_hs, a_vs, a_ad}), 32'(e.a_pix));
        chk("a_active_sel", e.cyc, 32'(a_as), 32'(e.a_sel));
        chk("a_busy", e.cyc, 32'(a_busy), 32'(e.a_busy));
        chk("b_pixel", e.cyc, 32'({b_r, b_g, b_b, b_hs, b_vs, b_ad}), 32'(e.b_pix));
        chk("b_active_sel", e.cyc, 32'(b_as), 32'(e.b_sel));
        chk("b_busy", e.cyc, 32'(b_busy), 32'(e.b_busy));
      end
    end
  end

  task automatic req_a(input int s, input int m);
    a_valid = 1'b1;
    a_sel   = 2'(s);
    a_mode  = m[0];
  endtask

  task automatic req_b(input int s, input int m);
    b_valid = 1'b1;
    b_sel   = 3'(s);
    b_mode  = m[0];
  endtask

  initial begin : stimulus
    int          ea_sel, eb_sel;
    bit          ea_mode, ea_blank, ea_busy, eb_mode, eb_busy;
    logic [26:0] px;
    exp_t        e;
    ea_sel = 0; ea_mode = 0; ea_blank = 0; ea_busy = 0;
    eb_sel = 0; eb_mode = 0; eb_busy = 0;
    a_sel = '0; a_mode = 1'b0; b_sel = '0; b_mode = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      int pos;
      pos = c % FRAME;
      for (int s = 0; s < 5; s++) begin
        px = src_pix(s, pos);
        s_red[s] = px[26:19]; s_green[s] = px[18:11]; s_blue[s] = px[10:3];
        s_hs[s]  = px[2];     s_vs[s]    = px[1];     s_act[s]  = px[0];
      end
      rst_n   = !(c < 4 || (c >= 230 && c < 233));
      a_valid = 1'b0;
      b_valid = 1'b0;
      // Expected values below are the post-edge state for cycle c.
      case (c)
        20:  begin req_a(2, 0); ea_busy = 1; req_b(5, 0); end
        24:  req_b(0, 0);
        32:  begin ea_sel = 2; ea_blank = 1; end
        36:  begin req_b(1, 0); eb_busy = 1; end
        40:  req_b(3, 0);
        48:  begin ea_blank = 0; ea_busy = 0; eb_sel = 3; eb_busy = 0; end
        56:  req_a(2, 0);
        60:  begin req_a(1, 1); ea_busy = 1; req_b(4, 1); eb_busy = 1; end
        64:  begin ea_sel = 1; ea_mode = 1; ea_blank = 1; eb_sel = 4; eb_mode = 1; eb_busy = 0; end
        80:  begin ea_blank = 0; ea_busy = 0; end
        100: begin req_a(3, 0); ea_busy = 1; req_b(1, 0); eb_busy = 1; end
        112: begin req_a(2, 0); ea_sel = 3; ea_mode = 0; req_b(2, 0); eb_sel = 1; eb_mode = 0; end
        128: begin ea_sel = 2; ea_blank = 1; eb_sel = 2; eb_busy = 0; end
        144: begin ea_blank = 0; ea_busy = 0; end
        160: begin req_a(1, 0); ea_busy = 1; end
        176: begin ea_sel = 1; ea_blank = 1; end
        180: begin req_a(3, 0); ea_blank = 0; end
        192: begin ea_sel = 3; ea_blank = 1; end
        208: begin ea_blank = 0; ea_busy = 0; end
        212: begin req_a(2, 0); ea_busy = 1; end
        224: begin ea_sel = 2; ea_blank = 1; end
        230: begin
          ea_sel = 0; ea_mode = 0; ea_blank = 0; ea_busy = 0;
          eb_sel = 0; eb_mode = 0; eb_busy = 0;
        end
        default: ;
      endcase
      e.cyc    = c;
      e.a_pix  = exp_pix(ea_sel, ea_mode, ea_blank, rst_n, pos);
      e.a_sel  = ea_sel;
      e.a_busy = ea_busy;
      e.b_pix  = exp_pix(eb_sel, eb_mode, 1'b0, rst_n, pos);
      e.b_sel  = eb_sel;
      e.b_busy = eb_busy;
      @(posedge clk_100_passthrough);
      q.push_back(e);
      #2;
    end
    repeat (3) @(posedge clk_100_passthrough);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
